usb_hid_kbd_decoder: RTL
========================

// Module: usb_hid_kbd_decoder
// PURPOSE
//  Downstream consumer of the low-speed USB PHY receive path. Captures boot-protocol keyboard
//  reports (PID, modifier byte, four keycode bytes), diffs each one against the last accepted
//  report, and emits make/break key events into an event FIFO for the 286 keyboard-controller side.
//  Converts level-style HID reports into the edge-style key events that legacy keyboard logic needs.
// PARAMETERS
//  FIFO_DEPTH   16   event FIFO entries, power of two, >= 4
//  MIN_BITS     64   minimum recv_size (sync+PID+6 bytes) for a report to be accepted
// PORTS
//  clk          in   1   system clock, single clock domain
//  reset        in   1   synchronous, active-high reset
//  connected    in   1   device present, level from PHY
//  recv_toggle  in   1   PHY recv_out; every transition marks a new received packet
//  recv_size    in   7   received bit count, valid when recv_toggle changes
//  pid          in   8   PHY last_received_packet_type
//  byte2        in   8   modifier byte
//  byte4..byte7 in   8   keycode slots 0..3; byte3 (reserved) is not connected
//  ev_valid     out  1   FIFO head valid
//  ev_data      out  9   {make(1)/break(0), code[7:0]}
//  ev_ready     in   1   consumer pops head when ev_valid & ev_ready
//  overflow     out  1   one-cycle pulse per event dropped because the FIFO was full
//  busy         out  1   diff engine is not in S_IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, old report (mod, keys) = 0, pending = 0, state S_IDLE.
//  - recv_toggle is registered once; edge = toggle != registered value (1 cycle of latency).
//  - Edge is accepted when pid is 8'hC3 or 8'h4B, recv_size >= MIN_BITS, and not all four keys
//    are 8'h01 (phantom/rollover report, discarded). Accepted: {byte2, byte4..7} -> pending, pend=1.
//    A newer accepted report overwrites pending; the latest always wins. Others are ignored.
//  - connected 1->0 (registered edge) loads an all-zero pending report, releasing every held key.
//  - FSM: S_IDLE -> (pend) S_LOAD: new=pending, pend=0 -> S_MOD -> S_BREAK -> S_MAKE -> S_COMMIT
//    -> S_IDLE. A pend set during the same cycle as S_LOAD is kept for the next pass.
//  - S_MOD: 8 cycles, i=0..7; if old.mod[i]!=new.mod[i] push {new.mod[i], 8'hE0+i}.
//  - S_BREAK: 4 cycles, slot j; if old.key[j]!=0 and not in new.key[0..3], push {0, old.key[j]}.
//  - S_MAKE: 4 cycles, slot j; if new.key[j]!=0 and not in old.key[0..3], push {1, new.key[j]}.
//    Duplicate keycodes inside one report produce one event per slot (no dedup).
//  - S_COMMIT: old=new. A pass therefore takes exactly 18 cycles (LOAD+8+4+4+COMMIT), regardless
//    of how many events it generates.
//  - Push into a full FIFO: event dropped, overflow pulses, FIFO contents unchanged. Same-cycle
//    push+pop when full: the pop frees a slot and the push is accepted (no overflow).
//  - FIFO: first-word-fall-through; ev_data is stable while ev_valid & !ev_ready; count wraps
//    with pointers of log2(FIFO_DEPTH)+1 bits.
//  - Reset mid-pass: aborts to S_IDLE, old report cleared, FIFO flushed, no events emitted.
//  - Key order inside a pass: modifiers LSB first, then breaks slot 0..3, then makes slot 0..3.
// STRUCTURE
//  - usb_hid_pkg: PID_DATA0=8'hC3, PID_DATA1=8'h4B, PHANTOM=8'h01, MOD_BASE=8'hE0,
//    EV_W=9, state encoding localparams.
//  - Sub-module kbd_event_fifo (FIFO_DEPTH, EV_W): sync FWFT FIFO with push/full/pop/empty.
//  - Top: toggle/connected edge detect, pending buffer, diff FSM, comparison of 1 key vs 4.
// TESTING
//  1 Report DATA0, size 96, mod 0, keys {04,00,00,00} -> one event {1,04}; busy high 18 cycles.
//  2 Then keys {00,00,00,00} -> {0,04}; then mod 8'h22 -> {1,E1},{1,E5} in that order.
//  3 Keys {04,05,00,00} -> {04,06,00,00}: events {0,05} then {1,06}; pid 8'h5A (NAK) -> none.
//  4 Phantom {01,01,01,01} or recv_size=40 -> no events, old report kept; next valid diffs vs it.
//  5 ev_ready=0, 20 key changes into a 16-deep FIFO -> 16 stored in order, 4 overflow pulses.
//  6 Holding {04,05}, connected drops -> {0,04},{0,05}; reset mid-pass -> FIFO empty, ev_valid=0.

Source files
------------

// File: rtl/usb_hid_kbd_decoder_pkg.sv
// Shared definitions for the boot-protocol keyboard decoder.
//  - PID values accepted as report carriers, phantom keycode, modifier usage base
//  - event word width: {make/break, keycode[7:0]}
//  - diff-engine state encoding (plain localparams so older tools can consume them)
//  - report_t: one captured report (modifier byte plus four keycode slots)
//  - keyPresent(): "is this keycode anywhere in these four slots"
package usb_hid_kbd_decoder_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PHANTOM   = 8'h01;
  localparam logic [7:0] MOD_BASE  = 8'hE0;
  localparam int         EV_W      = 9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_MOD    = 3'd2;
  localparam logic [2:0] S_BREAK  = 3'd3;
  localparam logic [2:0] S_MAKE   = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  // key[0] is the first keycode byte on the wire (byte4), key[3] the last (byte7)
  typedef struct packed {
    logic [7:0]      mod;
    logic [3:0][7:0] key;
  } report_t;

  function automatic logic keyPresent(input logic [7:0] code, input logic [3:0][7:0] keys);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (keys[s] == code) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/usb_hid_kbd_decoder_if.sv
// Key-event stream between the decoder and the keyboard-controller side.
//  ev_valid  event FIFO head is valid
//  ev_data   {make(1)/break(0), keycode[7:0]}
//  ev_ready  consumer takes the head when ev_valid & ev_ready
// master = event producer (decoder), slave = event consumer.
interface usb_hid_kbd_decoder_if;
  import usb_hid_kbd_decoder_pkg::*;

  logic            ev_valid;
  logic [EV_W-1:0] ev_data;
  logic            ev_ready;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/usb_hid_kbd_decoder_kbd_event_fifo.sv
// Synchronous first-word-fall-through event FIFO.
//  clk, reset   single clock, synchronous active-high reset (flushes the FIFO)
//  push_i       write request, data_i is the event word
//  pop_i        consumer pop request, ignored while empty
//  data_o       head entry, forced to 0 while empty
//  valid_o      FIFO not empty
//  overflow_o   one-cycle pulse for each push dropped because the FIFO was full
module usb_hid_kbd_decoder_kbd_event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q;
  logic [AW:0]  rdPtr_q;
  logic [AW:0]  count;
  logic         empty;
  logic         full;
  logic         popOk;
  logic         pushOk;
  logic         overflow_q;

  // Pointers carry one extra bit so full and empty stay distinguishable after wrapping.
  // A pop in the same cycle as a push into a full FIFO frees the slot the push needs.
  always_comb begin
    count  = wrPtr_q - rdPtr_q;
    empty  = (count == '0);
    full   = (count == DEPTH[AW:0]);
    popOk  = pop_i & ~empty;
    pushOk = push_i & (~full | popOk);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
      overflow_q <= push_i & ~pushOk;
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (pushOk && !reset) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

  assign data_o     = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];
  assign valid_o    = ~empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/usb_hid_kbd_decoder.sv
// Boot-protocol keyboard report decoder. Captures reports from the low-speed PHY receive
// path, diffs each against the last accepted one and queues make/break key events.
//  clk, reset          single clock, synchronous active-high reset
//  connected           device-present level; a falling edge releases every held key
//  recv_toggle         flips once per received packet
//  recv_size           received bit count, qualifies the packet
//  pid                 packet type; only DATA0/DATA1 carry reports
//  byte2               modifier byte
//  byte4..byte7        keycode slots 0..3
//  ev                  event stream (master side): ev_valid/ev_data out, ev_ready in
//  overflow            pulse per event dropped on a full FIFO
//  busy                diff engine is running a pass
module usb_hid_kbd_decoder
  import usb_hid_kbd_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_BITS   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  connected,
  input  logic                  recv_toggle,
  input  logic [6:0]            recv_size,
  input  logic [7:0]            pid,
  input  logic [7:0]            byte2,
  input  logic [7:0]            byte4,
  input  logic [7:0]            byte5,
  input  logic [7:0]            byte6,
  input  logic [7:0]            byte7,
  usb_hid_kbd_decoder_if.master ev,
  output logic                  overflow,
  output logic                  busy
);

  logic            toggle_q;
  logic            conn_q;
  logic            pend_q, pend_d;
  report_t         pendRpt_q, pendRpt_d;
  report_t         newRpt_q;
  report_t         oldRpt_q;
  logic [2:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            rxEdge;
  logic            connFall;
  logic            accept;
  logic [7:0]      oldKey;
  logic [7:0]      newKey;
  logic            push;
  logic [EV_W-1:0] pushData;
  logic            fifoValid;
  logic [EV_W-1:0] fifoData;

  // A packet qualifies as a report when it is a data packet of full length and is not the
  // all-phantom rollover report the keyboard sends when too many keys are down.
  always_comb begin
    rxEdge   = recv_toggle != toggle_q;
    connFall = conn_q & ~connected;
    accept   = rxEdge
             & ((pid == PID_DATA0) | (pid == PID_DATA1))
             & (recv_size >= MIN_BITS[6:0])
             & ~((byte4 == PHANTOM) & (byte5 == PHANTOM) & (byte6 == PHANTOM) & (byte7 == PHANTOM));
  end

  // Single pending slot: the newest report always replaces an unconsumed one. A disconnect
  // wins over a simultaneous report so the release is never lost. A report arriving while
  // the engine is loading keeps pend set, so it gets its own pass afterwards.
  always_comb begin
    pendRpt_d = pendRpt_q;
    pend_d    = pend_q;
    if (state_q == S_LOAD) pend_d = 1'b0;
    if (connFall) begin
      pendRpt_d = '0;
      pend_d    = 1'b1;
    end else if (accept) begin
      pendRpt_d.mod = byte2;
      pendRpt_d.key = {byte7, byte6, byte5, byte4};
      pend_d        = 1'b1;
    end
  end

  // Diff engine. Every pass walks all 8 modifier bits, then all 4 old slots (breaks), then
  // all 4 new slots (makes), one step per cycle, so pass length never depends on content.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    push     = 1'b0;
    pushData = '0;
    oldKey   = oldRpt_q.key[idx_q[1:0]];
    newKey   = newRpt_q.key[idx_q[1:0]];
    case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_MOD;
        idx_d   = '0;
      end
      S_MOD: begin
        push     = oldRpt_q.mod[idx_q] != newRpt_q.mod[idx_q];
        pushData = {newRpt_q.mod[idx_q], MOD_BASE + {5'd0, idx_q}};
        if (idx_q == 3'd7) begin
          state_d = S_BREAK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_BREAK: begin
        push     = (oldKey != 8'h00) && !keyPresent(oldKey, newRpt_q.key);
        pushData = {1'b0, oldKey};
        if (idx_q == 3'd3) begin
          state_d = S_MAKE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_MAKE: begin
        push     = (newKey != 8'h00) && !keyPresent(newKey, oldRpt_q.key);
        pushData = {1'b1, newKey};
        if (idx_q == 3'd3) begin
          state_d = S_COMMIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Edge registers sample the live level during reset so a toggle or connected level that
  // is already high does not look like a fresh packet or a disconnect once reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q  <= recv_toggle;
      conn_q    <= connected;
      pend_q    <= 1'b0;
      pendRpt_q <= '0;
      newRpt_q  <= '0;
      oldRpt_q  <= '0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
    end else begin
      toggle_q  <= recv_toggle;
      conn_q    <= connected;
      pend_q    <= pend_d;
      pendRpt_q <= pendRpt_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      if (state_q == S_LOAD)   newRpt_q <= pendRpt_q;
      if (state_q == S_COMMIT) oldRpt_q <= newRpt_q;
    end
  end

  usb_hid_kbd_decoder_kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .data_i     (pushData),
    .pop_i      (ev.ev_ready),
    .data_o     (fifoData),
    .valid_o    (fifoValid),
    .overflow_o (overflow)
  );

  assign ev.ev_valid = fifoValid;
  assign ev.ev_data  = fifoData;
  assign busy        = (state_q != S_IDLE);

endmodule
